// File: rtl/lock_write_gate.sv
// lock_write_gate: gates bus writes into a lockable config register, unlocked by a two-word key sequence.
module lock_write_gate #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] KEY0          = 8'hA5,
  parameter logic [WIDTH-1:0] KEY1          = 8'h5A,
  parameter int               UNLOCK_WINDOW = 16,
  parameter int               MAX_FAIL      = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_req_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             lock_req_i,
  input  logic             key_valid_i,
  input  logic [WIDTH-1:0] key_data_i,
  output logic             write_en_o,
  output logic [WIDTH-1:0] data_out_o,
  output logic             locked_o,
  output logic             key_stage_o,
  output logic             lockout_o,
  output logic             violation_o
);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(UNLOCK_WINDOW + 1);
  localparam logic [1:0] S_OPEN     = 2'd0;
  localparam logic [1:0] S_LOCKED   = 2'd1;
  localparam logic [1:0] S_KEY_WAIT = 2'd2;
  localparam logic [1:0] S_LOCKOUT  = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [FW-1:0]    fail_cnt_q, fail_cnt_d, fail_inc;
  logic [TW-1:0]    timer_q, timer_d;
  logic             write_en_q, write_en_d, violation_q, violation_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       fail_state;
  logic             open;
  assign open       = state_q == S_OPEN;
  assign fail_inc   = (fail_cnt_q == FW'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + 1'b1;
  assign fail_state = (fail_inc == FW'(MAX_FAIL)) ? S_LOCKOUT : S_LOCKED;
  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    case (state_q)
      S_OPEN: state_d = lock_req_i ? S_LOCKED : S_OPEN;
      S_LOCKED:
        if (key_valid_i && key_data_i == KEY0) begin
          state_d = S_KEY_WAIT;
          timer_d = TW'(UNLOCK_WINDOW);
        end else if (key_valid_i) begin
          state_d    = fail_state;
          fail_cnt_d = fail_inc;
        end
      S_KEY_WAIT:
        // lock_req wins over any key and does not count as a failure
        if (lock_req_i) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end else if (key_valid_i && key_data_i == KEY1) begin
          state_d    = S_OPEN;
          fail_cnt_d = '0;
          timer_d    = '0;
        end else if (key_valid_i || timer_q == TW'(1)) begin
          state_d    = fail_state;
          fail_cnt_d = fail_inc;
          timer_d    = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      default: state_d = S_LOCKOUT;
    endcase
  end
  assign write_en_d  = open && wr_req_i;
  assign violation_d = !open && wr_req_i;
  assign data_d      = write_en_d ? wr_data_i : data_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_OPEN;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
      write_en_q  <= 1'b0;
      violation_q <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
      write_en_q  <= write_en_d;
      violation_q <= violation_d;
      data_q      <= data_d;
    end
  end
  assign write_en_o  = write_en_q;
  assign violation_o = violation_q;
  assign data_out_o  = data_q;
  assign locked_o    = !open;
  assign key_stage_o = state_q == S_KEY_WAIT;
  assign lockout_o   = state_q == S_LOCKOUT;
endmodule

// File: tb/tb_lock_write_gate.sv
// tb_lock_write_gate: directed self-checking bench for lock_write_gate.
module tb_lock_write_gate;
  logic       clk = 1'b0;
  logic       resetn, wr_req, lock_req, key_valid;
  logic [7:0] wr_data, key_data;
  logic       write_en, locked, key_stage, lockout, violation;
  logic [7:0] data_out;
  int checks = 0;
  int errors = 0;
  lock_write_gate dut (
    .clk(clk), .resetn(resetn), .wr_req_i(wr_req), .wr_data_i(wr_data),
    .lock_req_i(lock_req), .key_valid_i(key_valid), .key_data_i(key_data),
    .write_en_o(write_en), .data_out_o(data_out), .locked_o(locked),
    .key_stage_o(key_stage), .lockout_o(lockout), .violation_o(violation)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic key(input logic [7:0] k);
    key_valid = 1'b1;
    key_data  = k;
    tick();
    key_valid = 1'b0;
  endtask
  initial begin
    resetn = 0; wr_req = 0; lock_req = 0; key_valid = 0; wr_data = 0; key_data = 0;
    tick(); tick();
    resetn = 1;
    chk("rst_we", write_en, 0); chk("rst_data", data_out, 0); chk("rst_viol", violation, 0);
    chk("rst_locked", locked, 0); chk("rst_kstage", key_stage, 0); chk("rst_lockout", lockout, 0);
    // 1: open write
    wr_req = 1; wr_data = 8'h3C; tick(); wr_req = 0;
    chk("t1_we", write_en, 1); chk("t1_data", data_out, 8'h3C); chk("t1_viol", violation, 0);
    tick();
    chk("t1_we_pulse", write_en, 0); chk("t1_hold", data_out, 8'h3C);
    wr_req = 1; wr_data = 8'h01; tick();
    chk("b2b_we0", write_en, 1); chk("b2b_d0", data_out, 8'h01);
    wr_data = 8'h02; tick(); wr_req = 0;
    chk("b2b_we1", write_en, 1); chk("b2b_d1", data_out, 8'h02);
    key(8'hA5);
    chk("open_key_ignored", key_stage, 0);
    // 2: write before lock, then blocked
    lock_req = 1; wr_req = 1; wr_data = 8'h11; tick(); lock_req = 0;
    chk("t2_we", write_en, 1); chk("t2_data", data_out, 8'h11); chk("t2_locked", locked, 1);
    wr_data = 8'h22; tick(); wr_req = 0;
    chk("t2_blk_we", write_en, 0); chk("t2_viol", violation, 1); chk("t2_hold", data_out, 8'h11);
    tick();
    chk("t2_viol_pulse", violation, 0);
    // 3: valid unlock
    key(8'hA5);
    chk("t3_kstage", key_stage, 1);
    repeat (4) tick();
    chk("t3_still_wait", key_stage, 1);
    key(8'h5A);
    chk("t3_unlocked", locked, 0); chk("t3_kstage0", key_stage, 0);
    wr_req = 1; wr_data = 8'h77; tick(); wr_req = 0;
    chk("t3_we", write_en, 1); chk("t3_data", data_out, 8'h77);
    // 4: timeout after 16 idle cycles, then late KEY1 fails
    lock_req = 1; tick(); lock_req = 0;
    key(8'hA5);
    repeat (15) tick();
    chk("t4_wait16", key_stage, 1);
    tick();
    chk("t4_timeout", key_stage, 0); chk("t4_locked", locked, 1); chk("t4_no_lockout", lockout, 0);
    key(8'h5A);
    chk("t4_late_key1", locked, 1); chk("t4_late_kstage", key_stage, 0); chk("t4_two_fails", lockout, 0);
    key(8'h00);
    chk("t4_third_fail", lockout, 1);
    // 5: three bad keys from fresh reset
    resetn = 0; tick(); resetn = 1;
    chk("t5_rst_lockout", lockout, 0);
    lock_req = 1; tick(); lock_req = 0;
    key(8'h00); key(8'h00);
    chk("t5_two_bad", lockout, 0);
    key(8'h00);
    chk("t5_lockout", lockout, 1); chk("t5_locked", locked, 1);
    key(8'hA5);
    key(8'h5A);
    chk("t5_keys_ignored", lockout, 1); chk("t5_kstage", key_stage, 0);
    lock_req = 1; wr_req = 1; wr_data = 8'h99; tick(); wr_req = 0; lock_req = 0;
    chk("t5_we", write_en, 0); chk("t5_viol", violation, 1); chk("t5_data", data_out, 0);
    chk("t5_still_lockout", lockout, 1);
    resetn = 0; tick(); resetn = 1;
    chk("t5_reset_open", locked, 0); chk("t5_reset_lockout", lockout, 0); chk("t5_reset_viol", violation, 0);
    // lock_req in KEY_WAIT beats a correct KEY1 and counts no failure
    lock_req = 1; tick(); lock_req = 0;
    key(8'hA5);
    lock_req = 1; key(8'h5A); lock_req = 0;
    chk("prio_locked", locked, 1); chk("prio_kstage", key_stage, 0);
    key(8'h33); key(8'h33);
    chk("prio_no_fail", lockout, 0);
    key(8'h33);
    chk("prio_lockout", lockout, 1);
    // 6: reset during KEY_WAIT with wr_req high
    resetn = 0; tick(); resetn = 1;
    wr_req = 1; wr_data = 8'h5E; tick(); wr_req = 0;
    chk("t6_pre_data", data_out, 8'h5E);
    lock_req = 1; tick(); lock_req = 0;
    key(8'hA5);
    chk("t6_kstage", key_stage, 1);
    resetn = 0; wr_req = 1; wr_data = 8'hEE; tick(); resetn = 1; wr_req = 0;
    chk("t6_we", write_en, 0); chk("t6_data", data_out, 0); chk("t6_locked", locked, 0);
    chk("t6_kstage0", key_stage, 0); chk("t6_viol", violation, 0);
    // timer cleared: fresh KEY0 still gets a full window
    lock_req = 1; tick(); lock_req = 0;
    key(8'hA5);
    repeat (15) tick();
    chk("t6_full_window", key_stage, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
